alu_share_arbiter: RTL and testbench

//  Shares one 64-bit ALU core (ADD/SUB/AND/XOR) between two requesters over valid/ready handshakes.

---
 rtl/alu_arb_pkg.sv | 30 +++
 rtl/alu64_core.sv | 61 ++++++
 rtl/alu_share_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - ALU function codes (ADD/SUB/AND/XOR)
//   - arbiter FSM state encoding
//   - bit positions of the {ZF,SF,OF} condition-code vector
// -----------------------------------------------------------------------------
package alu_arb_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int FN_W_DEF  = 2;
    localparam int CC_W      = 3;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    // Condition-code vector layout: {ZF,SF,OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage : alu_arb_pkg

// File: rtl/alu64_core.sv
// -----------------------------------------------------------------------------
// alu64_core
// Purely combinational ALU: ADD / SUB / AND / XOR on two's-complement operands,
// result wraps mod 2^WIDTH. Also produces Y86-style flags.
// Ports:
//   i_a, i_b  in  WIDTH  operands
//   i_fn      in  FN_W   function code (see alu_arb_pkg)
//   o_out     out WIDTH  result
//   o_zf      out 1      result == 0
//   o_sf      out 1      result sign bit
//   o_of      out 1      signed overflow (ADD/SUB only, 0 for logic ops)
// -----------------------------------------------------------------------------
module alu64_core
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FN_W  = FN_W_DEF
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [FN_W-1:0]  i_fn,
    output logic [WIDTH-1:0] o_out,
    output logic             o_zf,
    output logic             o_sf,
    output logic             o_of
);

    logic w_sa;
    logic w_sb;
    logic w_so;

    always_comb begin
        o_out = '0;
        case (i_fn)
            ALU_ADD: o_out = i_a + i_b;
            ALU_SUB: o_out = i_a - i_b;
            ALU_AND: o_out = i_a & i_b;
            ALU_XOR: o_out = i_a ^ i_b;
            default: o_out = '0;
        endcase
    end

    assign w_sa = i_a[WIDTH-1];
    assign w_sb = i_b[WIDTH-1];
    assign w_so = o_out[WIDTH-1];

    // Overflow: ADD when both operand signs agree and the result sign differs;
    // SUB when operand signs differ and the result sign differs from a.
    always_comb begin
        o_of = 1'b0;
        case (i_fn)
            ALU_ADD: o_of = (w_sa == w_sb) && (w_so != w_sa);
            ALU_SUB: o_of = (w_sa != w_sb) && (w_so != w_sa);
            default: o_of = 1'b0;
        endcase
    end

    assign o_zf = (o_out == '0);
    assign o_sf = w_so;

endmodule : alu64_core

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one ALU core between two requesters over valid/ready handshakes.
// A grant latches operands/function/owner, one registered execute cycle
// computes the result, and the result is held until the owner takes it.
// Round-robin: after each completed response the other requester has priority.
//
// Optional feature: define ALU_ARB_CC_EN to add the resp_cc port and the
// {ZF,SF,OF} condition-code register.
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst_n        in   1      synchronous reset, active-low
//   req_valid    in   2      bit i: requester i presents an op
//   req_ready    out  2      bit i: requester i's op accepted this cycle
//   req0_a/b     in   WIDTH  requester 0 operands
//   req0_fn      in   FN_W   requester 0 function
//   req1_a/b     in   WIDTH  requester 1 operands
//   req1_fn      in   FN_W   requester 1 function
//   resp_valid   out  2      bit i: result for requester i valid
//   resp_ready   in   2      bit i: requester i takes result
//   resp_result  out  WIDTH  registered result
//   resp_cc      out  3      {ZF,SF,OF} (ALU_ARB_CC_EN only)
//   busy         out  1      FSM not idle
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational on req_ready
// EXEC  | latched op goes through the ALU; result/flags registered
// RESP  | result presented to owner until its resp_ready
// -----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FN_W  = FN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FN_W-1:0]  req0_fn,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FN_W-1:0]  req1_fn,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_result,
`ifdef ALU_ARB_CC_EN
    output logic [2:0]       resp_cc,
`endif
    output logic             busy
);

    state_t           r_state;
    logic             r_rr_ptr;
    logic             r_owner;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [FN_W-1:0]  r_fn;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_resp_valid;

    logic             w_grant_en;
    logic             w_grant_idx;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [FN_W-1:0]  w_sel_fn;
    logic             w_resp_fire;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_zf;
    logic             w_sf;
    logic             w_of;

    // Lone requester wins outright; on contention the rr pointer decides.
    always_comb begin
        w_grant_idx = r_rr_ptr;
        case (req_valid)
            2'b01:   w_grant_idx = 1'b0;
            2'b10:   w_grant_idx = 1'b1;
            default: w_grant_idx = r_rr_ptr;
        endcase
    end

    assign w_grant_en = (r_state == IDLE) && (req_valid != 2'b00);

    always_comb begin
        req_ready = 2'b00;
        if (w_grant_en) begin
            req_ready = w_grant_idx ? 2'b10 : 2'b01;
        end
    end

    assign w_sel_a  = w_grant_idx ? req1_a  : req0_a;
    assign w_sel_b  = w_grant_idx ? req1_b  : req0_b;
    assign w_sel_fn = w_grant_idx ? req1_fn : req0_fn;

    // Only the owner's resp_ready completes the response.
    assign w_resp_fire = (r_state == RESP) && resp_ready[r_owner];

    alu64_core #(
        .WIDTH (WIDTH),
        .FN_W  (FN_W)
    ) u_alu (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_fn  (r_fn),
        .o_out (w_alu_out),
        .o_zf  (w_zf),
        .o_sf  (w_sf),
        .o_of  (w_of)
    );

`ifdef ALU_ARB_CC_EN
    logic [2:0] r_cc;
    logic [2:0] w_cc_next;

    always_comb begin
        w_cc_next        = 3'b000;
        w_cc_next[CC_ZF] = w_zf;
        w_cc_next[CC_SF] = w_sf;
        w_cc_next[CC_OF] = w_of;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cc <= 3'b000;
        end else if (r_state == EXEC) begin
            r_cc <= w_cc_next;
        end
    end

    assign resp_cc = r_cc;
`else
    // Flags are computed by the shared core but have no destination here.
    logic [2:0] w_cc_unused;
    assign w_cc_unused = {w_zf, w_sf, w_of};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= 1'b0;
            r_owner      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_fn         <= '0;
            r_result     <= '0;
            r_resp_valid <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_en) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_fn    <= w_sel_fn;
                        r_owner <= w_grant_idx;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_result     <= w_alu_out;
                    r_resp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (w_resp_fire) begin
                        r_resp_valid <= 2'b00;
                        r_rr_ptr     <= ~r_owner;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 2'b00;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_result = r_result;
    assign busy        = (r_state != IDLE);

endmodule : alu_share_arbiter

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int W = 64;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [1:0]    req0_fn, req1_fn;
    logic [1:0]    resp_valid;
    logic [1:0]    resp_ready;
    logic [W-1:0]  resp_result;
`ifdef ALU_ARB_CC_EN
    logic [2:0]    resp_cc;
`endif
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic         owner;
        logic [W-1:0] res;
        logic [2:0]   cc;
    } exp_t;

    exp_t sb_q[$];

    alu_share_arbiter #(.WIDTH(W), .FN_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_fn     (req0_fn),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_fn     (req1_fn),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
`ifdef ALU_ARB_CC_EN
        .resp_cc     (resp_cc),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic owner, input logic [W-1:0] res, input logic [2:0] cc);
        exp_t e;
        e.owner = owner;
        e.res   = res;
        e.cc    = cc;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: compares each completed response handshake.
    always @(negedge clk) begin
        if (rst_n && resp_valid != 2'b00) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: resp_valid=%b with no op outstanding", resp_valid);
            end else if ((resp_valid & resp_ready) != 2'b00) begin
                exp_t e;
                e = sb_q.pop_front();
                check("resp_owner", {62'd0, resp_valid}, e.owner ? 64'd2 : 64'd1);
                check("resp_result", resp_result, e.res);
`ifdef ALU_ARB_CC_EN
                check("resp_cc", {61'd0, resp_cc}, {61'd0, e.cc});
`endif
            end
        end
    end

    task automatic drain();
        int cyc = 0;
        while (sb_q.size() != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check("drain_timeout", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    // Raise the requested valids, drop each one once accepted, then drain.
    task automatic run_ops(input logic [1:0] v);
        logic [1:0] acc;
        int cyc;
        acc = 2'b00;
        cyc = 0;
        @(posedge clk); #1;
        req_valid = v;
        while (acc != v && cyc < 50) begin
            @(negedge clk);
            check("ready_onehot", 64'(req_ready & (req_ready - 2'b01)), 64'd0);
            acc = acc | req_ready;
            @(posedge clk); #1;
            req_valid = v & ~acc;
            cyc++;
        end
        check("grant_timeout", {62'd0, acc}, {62'd0, v});
        req_valid = 2'b00;
        drain();
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = 2'b00;
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int cyc;
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        req0_a = '0; req0_b = '0; req0_fn = 2'b00;
        req1_a = '0; req1_b = '0; req1_fn = 2'b00;

        // 1. reset held 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {62'd0, req_ready}, 64'd0);
        check("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
        check("rst_result", resp_result, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
`ifdef ALU_ARB_CC_EN
        check("rst_cc", {61'd0, resp_cc}, 64'd0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", {63'd0, busy}, 64'd0);

        // 2. req0 XOR, cycle-exact latency
        @(posedge clk); #1;
        resp_ready = 2'b00;
        req0_a = 64'h3FF; req0_b = 64'h368; req0_fn = 2'b11;
        req_valid = 2'b01;
        push(1'b0, 64'h097, 3'b000);
        @(negedge clk);
        check("t2_ready_N", {62'd0, req_ready}, 64'd1);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        check("t2_exec_busy", {63'd0, busy}, 64'd1);
        check("t2_exec_noresp", {62'd0, resp_valid}, 64'd0);
        @(negedge clk);
        check("t2_resp_N2", {62'd0, resp_valid}, 64'd1);
        check("t2_result_N2", resp_result, 64'h097);
        @(posedge clk); #1 resp_ready = 2'b11;
        drain();

        // 3. both valid after reset: req0 first, then req1
        do_reset(1);
        req0_a = 64'd5; req0_b = 64'd7; req0_fn = 2'b00;
        req1_a = 64'd5; req1_b = 64'd7; req1_fn = 2'b01;
        push(1'b0, 64'd12, 3'b000);
        push(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010);
        run_ops(2'b11);

        // 4. flags: AND to zero (req0), signed ADD overflow (req1); rr back on req0
        req0_a = 64'h2AA; req0_b = 64'h155; req0_fn = 2'b10;
        req1_a = 64'h7FFF_FFFF_FFFF_FFFF; req1_b = 64'd1; req1_fn = 2'b00;
        push(1'b0, 64'd0, 3'b100);
        push(1'b1, 64'h8000_0000_0000_0000, 3'b011);
        run_ops(2'b11);
        // SUB overflow from requester 1 alone
        req1_a = 64'h8000_0000_0000_0000; req1_b = 64'd1; req1_fn = 2'b01;
        push(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001);
        run_ops(2'b10);

        // 5. backpressure with non-owner resp_ready high
        @(posedge clk); #1;
        resp_ready = 2'b10;
        req0_a = 64'd1; req0_b = 64'd2; req0_fn = 2'b00;
        req1_a = 64'd10; req1_b = 64'd3; req1_fn = 2'b01;
        req_valid = 2'b01;
        push(1'b0, 64'd3, 3'b000);
        push(1'b1, 64'd7, 3'b000);
        @(negedge clk);
        check("t5_grant0", {62'd0, req_ready}, 64'd1);
        @(posedge clk); #1 req_valid = 2'b10;
        cyc = 0;
        while (resp_valid == 2'b00 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) begin
            @(negedge clk);
            check("t5_hold_valid", {62'd0, resp_valid}, 64'd1);
            check("t5_hold_result", resp_result, 64'd3);
            check("t5_no_ready", {62'd0, req_ready}, 64'd0);
        end
        @(posedge clk); #1 resp_ready = 2'b11;
        cyc = 0;
        while (req_ready[1] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_grant1", {63'd0, req_ready[1]}, 64'd1);
        @(posedge clk); #1 req_valid = 2'b00;
        drain();

        // 6. reset during EXEC drops op and clears rr pointer
        @(posedge clk); #1;
        req0_a = 64'd100; req0_b = 64'd1; req0_fn = 2'b00;
        req_valid = 2'b01;
        @(negedge clk);
        check("t6_grant", {62'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("t6_exec", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_idle_busy", {63'd0, busy}, 64'd0);
        check("t6_no_resp", {62'd0, resp_valid}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_still_idle", {63'd0, busy}, 64'd0);
        req0_a = 64'hF0; req0_b = 64'h0F; req0_fn = 2'b11;
        req1_a = 64'd1; req1_b = 64'd1; req1_fn = 2'b01;
        push(1'b0, 64'hFF, 3'b000);
        push(1'b1, 64'd0, 3'b100);
        run_ops(2'b11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_share_arbiter
